lfsr_rr_scheduler: RTL and testbench
====================================

Name: lfsr_rr_scheduler

Overview:
Shares one 16-bit Fibonacci LFSR among NUM_REQ requesters using round-robin arbitration.
- Each granted request advances the LFSR STEPS_PER_GRANT times.
- The resulting value is returned to the winner with a one-cycle grant pulse.
- Also handles seeding of the LFSR.
- Sits between the pseudo-random consumers (test-pattern generators, backoff timers) and the shared LFSR datapath.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16
STEPS_PER_GRANT, 1, LFSR shifts per grant; legal range 1..16
SEED_DEFAULT, 16'hACE1, LFSR value after reset; must be non-zero

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
seed_load  input  1  load seed into LFSR; honoured only when seed_ready=1
seed  input  16  seed value
seed_ready  output  1  1 when FSM is in IDLE
req  input  NUM_REQ  per-requester request level; held high until own gnt bit seen
gnt  output  NUM_REQ  one-hot grant pulse, 1 cycle
rnd_valid  output  1  pulse coincident with gnt
rnd_data  output  16  LFSR value returned to winner; valid when rnd_valid=1
rnd_id  output  $clog2(NUM_REQ)  index of winner; valid when rnd_valid=1
busy  output  1  FSM not in IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- LFSR step: fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}. The LFSR shifts only in the STEP state.
- Reset, sampled on a clk edge with reset=1:
  - state=IDLE; lfsr=SEED_DEFAULT.
  - last_grant pointer = NUM_REQ-1, so requester 0 has top priority first.
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, busy=0.
- FSM states: IDLE, STEP, RESP.
- IDLE:
  - If seed_load=1: lfsr <= seed; stay IDLE. seed_load has priority over req in the same cycle; req stays pending.
  - Else if |req: winner = first asserted index scanning (last_grant+1) mod NUM_REQ upward with wrap. Latch owner, cnt <= STEPS_PER_GRANT, go STEP.
  - Else stay IDLE.
- STEP:
  - Each cycle: shift lfsr, cnt <= cnt-1.
  - When cnt==1: shift and go RESP.
  - STEP lasts exactly STEPS_PER_GRANT cycles.
- RESP, one cycle:
  - gnt[owner]=1, rnd_valid=1, rnd_data=lfsr (post-step), rnd_id=owner.
  - Next edge: last_grant <= owner, go IDLE.
- Latency: req sampled at IDLE edge E0 -> gnt visible in cycle E0+STEPS_PER_GRANT+1. Throughput: one grant per STEPS_PER_GRANT+2 cycles.
- Requester protocol:
  - A requester drops req on the edge ending its gnt cycle.
  - If req is still high in the following IDLE cycle, it counts as a new request at lowest priority.
- req changes during STEP/RESP are ignored. The owner cannot be withdrawn once latched.
- seed_load outside IDLE is ignored (no queueing); seed_ready=0 there.
- Reset mid-operation (STEP or RESP): transaction aborted, no gnt issued, lfsr reloaded with SEED_DEFAULT.
- Pointer wrap: after owner NUM_REQ-1, the search starts at 0.

Optional Feature:
Macro: LFSR_LOCKUP_GUARD_EN
- Defined:
  - A seed_load with seed==16'h0000 loads SEED_DEFAULT instead.
  - Sticky output seed_zero_err (1 bit) is set; it is cleared only by reset (reset value 0).
- Undefined:
  - seed_zero_err port absent.
  - A zero seed is loaded verbatim and the LFSR stays at 0; rnd_data=0 for every grant until the next non-zero seed_load.

Test Plan:
1. Reset, STEPS_PER_GRANT=1, req=4'b0001 held until gnt -> gnt=4'b0001, rnd_id=0, rnd_data=16'h59C3, 2 cycles after sampling edge.
2. seed_load=1 with seed=16'h0001 in IDLE, then req=4'b0100, STEPS_PER_GRANT=1 -> rnd_data=16'h0002, rnd_id=2; seed_load while busy=1 has no effect on rnd_data.
3. req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0,1; gnt one-hot; grants spaced STEPS_PER_GRANT+2 cycles apart.
4. STEPS_PER_GRANT=4, seed 16'h0001, req[1] -> rnd_data=16'h0010 after 4 STEP cycles; busy=1 for 5 cycles.
5. reset asserted during 2nd STEP cycle (STEPS_PER_GRANT=4) -> no gnt, busy=0 next cycle; next grant from req[0] returns 16'h59C3 (STEPS_PER_GRANT=1 build).
6. With LFSR_LOCKUP_GUARD_EN: seed_load seed=0 -> seed_zero_err=1 and lfsr=16'hACE1 (next grant 16'h59C3 at STEPS=1). Without the macro: every rnd_data=16'h0000.

Source files
------------

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin scheduler that lends one shared 16-bit Fibonacci LFSR to NUM_REQ requesters.
// Zero-seed lockup guard is enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_rr_scheduler #(
    parameter int          NUM_REQ         = 4,
    parameter int          STEPS_PER_GRANT = 1,
    parameter logic [15:0] SEED_DEFAULT    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seed_load,
    input  logic [15:0]                seed,
    output logic                       seed_ready,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rnd_valid,
    output logic [15:0]                rnd_data,
    output logic [$clog2(NUM_REQ)-1:0] rnd_id,
    output logic                       busy
`ifdef LFSR_LOCKUP_GUARD_EN
    ,
    output logic                       seed_zero_err
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]     state;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] owner;
    logic [4:0]     cnt;
    logic [IDW-1:0] win;
    logic           win_found;
    logic [15:0]    seed_eff;
    logic           fb;

    assign fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_next = {lfsr[14:0], fb};

`ifdef LFSR_LOCKUP_GUARD_EN
    // An all-zero state would freeze the LFSR forever, so substitute the default seed.
    assign seed_eff = (seed == 16'h0000) ? SEED_DEFAULT : seed;
`else
    assign seed_eff = seed;
`endif

    // Scan upward from the slot after the last winner, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lfsr       <= SEED_DEFAULT;
            last_grant <= IDW'(NUM_REQ - 1);
            owner      <= '0;
            cnt        <= '0;
            gnt        <= '0;
            rnd_valid  <= 1'b0;
            rnd_data   <= 16'h0000;
            rnd_id     <= '0;
            busy       <= 1'b0;
            seed_ready <= 1'b1;
`ifdef LFSR_LOCKUP_GUARD_EN
            seed_zero_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    // Seeding wins over arbitration; pending requests simply wait a cycle.
                    if (seed_load) begin
                        lfsr <= seed_eff;
`ifdef LFSR_LOCKUP_GUARD_EN
                        if (seed == 16'h0000) begin
                            seed_zero_err <= 1'b1;
                        end
`endif
                    end else if (win_found) begin
                        owner      <= win;
                        cnt        <= 5'(STEPS_PER_GRANT);
                        state      <= ST_STEP;
                        busy       <= 1'b1;
                        seed_ready <= 1'b0;
                    end
                end
                ST_STEP: begin
                    lfsr <= lfsr_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= ST_RESP;
                        gnt       <= NUM_REQ'(1) << owner;
                        rnd_valid <= 1'b1;
                        rnd_data  <= lfsr_next;
                        rnd_id    <= owner;
                    end
                end
                ST_RESP: begin
                    gnt        <= '0;
                    rnd_valid  <= 1'b0;
                    last_grant <= owner;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    seed_ready <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    gnt        <= '0;
                    rnd_valid  <= 1'b0;
                    busy       <= 1'b0;
                    seed_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench: one instance with STEPS_PER_GRANT=1 and one with STEPS_PER_GRANT=4.
module tb_lfsr_rr_scheduler;

    logic        clk;
    logic        reset1, reset4;
    logic        seed_load1, seed_load4;
    logic [15:0] seed1, seed4;
    logic [3:0]  req1, req4;
    logic        seed_ready1, seed_ready4;
    logic [3:0]  gnt1, gnt4;
    logic        rnd_valid1, rnd_valid4;
    logic [15:0] rnd_data1, rnd_data4;
    logic [1:0]  rnd_id1, rnd_id4;
    logic        busy1, busy4;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic        seed_zero_err1, seed_zero_err4;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_rr_scheduler #(.NUM_REQ(4), .STEPS_PER_GRANT(1), .SEED_DEFAULT(16'hACE1)) dut1 (
        .clk(clk), .reset(reset1), .seed_load(seed_load1), .seed(seed1),
        .seed_ready(seed_ready1), .req(req1), .gnt(gnt1), .rnd_valid(rnd_valid1),
        .rnd_data(rnd_data1), .rnd_id(rnd_id1), .busy(busy1)
`ifdef LFSR_LOCKUP_GUARD_EN
        , .seed_zero_err(seed_zero_err1)
`endif
    );

    lfsr_rr_scheduler #(.NUM_REQ(4), .STEPS_PER_GRANT(4), .SEED_DEFAULT(16'hACE1)) dut4 (
        .clk(clk), .reset(reset4), .seed_load(seed_load4), .seed(seed4),
        .seed_ready(seed_ready4), .req(req4), .gnt(gnt4), .rnd_valid(rnd_valid4),
        .rnd_data(rnd_data4), .rnd_id(rnd_id4), .busy(busy4)
`ifdef LFSR_LOCKUP_GUARD_EN
        , .seed_zero_err(seed_zero_err4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until gnt1 goes non-zero, bounded at 20.
    task automatic wait_gnt1(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt1 == 4'b0000 && cyc < 20);
    endtask

    task automatic test_reset();
        reset1 = 1'b1; reset4 = 1'b1;
        seed_load1 = 1'b0; seed_load4 = 1'b0;
        seed1 = 16'h0; seed4 = 16'h0;
        req1 = 4'b0; req4 = 4'b0;
        tick(); tick();
        checks++;
        if (gnt1 !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt1); end
        checks++;
        if (rnd_valid1 !== 1'b0 || busy1 !== 1'b0 || seed_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: rnd_valid=%b busy=%b seed_ready=%b expected 0 0 1", rnd_valid1, busy1, seed_ready1);
        end
        checks++;
        if (rnd_data1 !== 16'h0000 || rnd_id1 !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: rnd_data=%h rnd_id=%0d expected 0000 0", rnd_data1, rnd_id1);
        end
`ifdef LFSR_LOCKUP_GUARD_EN
        checks++;
        if (seed_zero_err1 !== 1'b0) begin failures++; $display("FAIL reset_zero_err: got %b expected 0", seed_zero_err1); end
`endif
        reset1 = 1'b0; reset4 = 1'b0;
    endtask

    task automatic test_basic_grant();
        int cyc;
        req1 = 4'b0001;
        tick();
        checks++;
        if (busy1 !== 1'b1 || gnt1 !== 4'b0000) begin
            failures++;
            $display("FAIL basic_step_cycle: busy=%b gnt=%b expected 1 0000", busy1, gnt1);
        end
        cyc = 1;
        if (gnt1 == 4'b0000) begin
            wait_gnt1(cyc);
            cyc++;
        end
        checks++;
        if (cyc !== 2) begin failures++; $display("FAIL basic_latency: got %0d cycles expected 2", cyc); end
        checks++;
        if (gnt1 !== 4'b0001 || rnd_valid1 !== 1'b1 || rnd_id1 !== 2'd0) begin
            failures++;
            $display("FAIL basic_gnt: gnt=%b valid=%b id=%0d expected 0001 1 0", gnt1, rnd_valid1, rnd_id1);
        end
        checks++;
        if (rnd_data1 !== 16'h59C3) begin failures++; $display("FAIL basic_data: got %h expected 59C3", rnd_data1); end
        req1 = 4'b0000;
        tick();
        checks++;
        if (gnt1 !== 4'b0000 || rnd_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse_end: gnt=%b valid=%b busy=%b expected 0000 0 0", gnt1, rnd_valid1, busy1);
        end
    endtask

    task automatic test_seed_load();
        int cyc;
        // seed_load and req in the same IDLE cycle: seed wins, request waits.
        seed_load1 = 1'b1; seed1 = 16'h0001; req1 = 4'b0100;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL seed_priority: busy=%b expected 0", busy1); end
        seed_load1 = 1'b0;
        tick();
        checks++;
        if (busy1 !== 1'b1 || seed_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL seed_busy: busy=%b seed_ready=%b expected 1 0", busy1, seed_ready1);
        end
        seed_load1 = 1'b1; seed1 = 16'hFFFF;
        tick();
        seed_load1 = 1'b0;
        checks++;
        if (gnt1 !== 4'b0100 || rnd_id1 !== 2'd2 || rnd_data1 !== 16'h0002) begin
            failures++;
            $display("FAIL seed_grant: gnt=%b id=%0d data=%h expected 0100 2 0002", gnt1, rnd_id1, rnd_data1);
        end
        req1 = 4'b0000;
        tick();
        req1 = 4'b0001;
        wait_gnt1(cyc);
        checks++;
        if (gnt1 !== 4'b0001 || rnd_data1 !== 16'h0004) begin
            failures++;
            $display("FAIL seed_busy_ignored: gnt=%b data=%h expected 0001 0004", gnt1, rnd_data1);
        end
        req1 = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_data [4];
        int cyc;
        exp_data[0] = 16'h59C3; exp_data[1] = 16'hB387;
        exp_data[2] = 16'h670F; exp_data[3] = 16'hCE1E;
        reset1 = 1'b1;
        tick();
        reset1 = 1'b0;
        req1 = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_gnt1(cyc);
            checks++;
            if (gnt1 !== (4'b0001 << (k % 4)) || rnd_id1 !== 2'(k % 4)) begin
                failures++;
                $display("FAIL rr_order[%0d]: gnt=%b id=%0d expected id %0d", k, gnt1, rnd_id1, k % 4);
            end
            checks++;
            if (cyc !== ((k == 0) ? 2 : 3)) begin
                failures++;
                $display("FAIL rr_spacing[%0d]: got %0d cycles expected %0d", k, cyc, (k == 0) ? 2 : 3);
            end
            if (k < 4) begin
                checks++;
                if (rnd_data1 !== exp_data[k]) begin
                    failures++;
                    $display("FAIL rr_data[%0d]: got %h expected %h", k, rnd_data1, exp_data[k]);
                end
            end
        end
        req1 = 4'b0000;
        tick();
    endtask

    task automatic test_multistep();
        int busy_cnt, at;
        logic [15:0] data;
        logic [1:0]  id;
        logic [3:0]  g;
        busy_cnt = 0; at = 0; data = 16'h0; id = 2'd0; g = 4'b0;
        seed_load4 = 1'b1; seed4 = 16'h0001;
        tick();
        seed_load4 = 1'b0;
        req4 = 4'b0010;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (busy4) busy_cnt++;
            if (gnt4 != 4'b0000 && at == 0) begin
                at = i; data = rnd_data4; id = rnd_id4; g = gnt4;
                req4 = 4'b0000;
            end
            if (!busy4) break;
        end
        checks++;
        if (at !== 5) begin failures++; $display("FAIL multi_latency: got %0d expected 5", at); end
        checks++;
        if (busy_cnt !== 5) begin failures++; $display("FAIL multi_busy: got %0d cycles expected 5", busy_cnt); end
        checks++;
        if (data !== 16'h0010 || id !== 2'd1 || g !== 4'b0010) begin
            failures++;
            $display("FAIL multi_data: data=%h id=%0d gnt=%b expected 0010 1 0010", data, id, g);
        end
    endtask

    task automatic test_reset_mid_step();
        int at;
        logic seen;
        logic [15:0] data;
        at = 0; seen = 1'b0; data = 16'h0;
        req4 = 4'b0001;
        tick();
        tick();
        reset4 = 1'b1;
        req4 = 4'b0000;
        tick();
        checks++;
        if (busy4 !== 1'b0 || gnt4 !== 4'b0000 || rnd_valid4 !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: busy=%b gnt=%b valid=%b expected 0 0000 0", busy4, gnt4, rnd_valid4);
        end
        reset4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt4 != 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_gnt: got a grant expected none"); end
        req4 = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (gnt4 != 4'b0000) begin at = i; data = rnd_data4; req4 = 4'b0000; break; end
        end
        checks++;
        if (at !== 5 || data !== 16'hCE1E) begin
            failures++;
            $display("FAIL abort_reseed: at=%0d data=%h expected 5 CE1E", at, data);
        end
        tick();
    endtask

    task automatic test_zero_seed();
        int cyc;
        seed_load1 = 1'b1; seed1 = 16'h0000;
        tick();
        seed_load1 = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        checks++;
        if (seed_zero_err1 !== 1'b1) begin failures++; $display("FAIL zero_err_set: got %b expected 1", seed_zero_err1); end
`endif
        req1 = 4'b0001;
        wait_gnt1(cyc);
        checks++;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (gnt1 !== 4'b0001 || rnd_data1 !== 16'h59C3) begin
            failures++;
            $display("FAIL zero_seed_first: gnt=%b data=%h expected 0001 59C3", gnt1, rnd_data1);
        end
`else
        if (gnt1 !== 4'b0001 || rnd_data1 !== 16'h0000) begin
            failures++;
            $display("FAIL zero_seed_first: gnt=%b data=%h expected 0001 0000", gnt1, rnd_data1);
        end
`endif
        req1 = 4'b0000;
        tick();
        req1 = 4'b0010;
        wait_gnt1(cyc);
        checks++;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (gnt1 !== 4'b0010 || rnd_data1 !== 16'hB387 || seed_zero_err1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_seed_second: gnt=%b data=%h err=%b expected 0010 B387 1", gnt1, rnd_data1, seed_zero_err1);
        end
`else
        if (gnt1 !== 4'b0010 || rnd_data1 !== 16'h0000) begin
            failures++;
            $display("FAIL zero_seed_second: gnt=%b data=%h expected 0010 0000", gnt1, rnd_data1);
        end
`endif
        req1 = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_seed_load();
        test_round_robin();
        test_multistep();
        test_reset_mid_step();
        test_zero_seed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
